// File: rtl/e_tile_operand_dispatch.sv
// Result fan-out stage: buffers fired ALU results and serialises each valid target
// as one req/ack handshake to the operand network or the R-bank W-queue.
module e_tile_operand_dispatch #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 64,
    parameter int NODE_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [1:0]                in_tgt_valid,
    input  logic [1:0]                in_tgt_wq,
    input  logic [13:0]               in_tgt_instr,
    input  logic [3:0]                in_tgt_slot,
    output logic                      net_req,
    output logic [DATA_W-1:0]         net_data,
    output logic [6:0]                net_dest_instr,
    output logic [1:0]                net_dest_slot,
    output logic [6:0]                net_src_node,
    input  logic                      net_ack,
    output logic                      wq_req,
    output logic [4:0]                wq_id,
    output logic [DATA_W-1:0]         wq_data,
    input  logic                      wq_ack,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND0 = 2'd1;
    localparam logic [1:0] ST_SEND1 = 2'd2;

    logic [DATA_W-1:0] data_mem_q  [DEPTH];
    logic [1:0]        tv_mem_q    [DEPTH];
    logic [1:0]        wq_mem_q    [DEPTH];
    logic [13:0]       instr_mem_q [DEPTH];
    logic [3:0]        slot_mem_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;

    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_tv, head_wq, nxt_tv;
    logic [13:0]       head_instr;
    logic [3:0]        head_slot;
    logic              sel1, sending, cur_wq, done, pop, push;
    logic [6:0]        cur_instr;
    logic [1:0]        cur_slot, after_pop;

    function automatic logic [1:0] start_state(input logic [1:0] tv);
        return tv[0] ? ST_SEND0 : ST_SEND1;
    endfunction

    assign head_data  = data_mem_q[rd_ptr_q];
    assign head_tv    = tv_mem_q[rd_ptr_q];
    assign head_wq    = wq_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_slot  = slot_mem_q[rd_ptr_q];
    assign nxt_tv     = tv_mem_q[rd_ptr_q + PW'(1)];

    assign in_ready     = !rst && !flush && (count_q < CW'(DEPTH));
    assign occupancy    = count_q;
    assign net_src_node = 7'(NODE_ID);

    // Current target selection, handshake completion and FIFO push/pop strobes.
    always_comb begin
        sel1      = (state_q == ST_SEND1);
        sending   = (state_q == ST_SEND0) || (state_q == ST_SEND1);
        cur_wq    = sel1 ? head_wq[1] : head_wq[0];
        cur_instr = sel1 ? head_instr[13:7] : head_instr[6:0];
        cur_slot  = sel1 ? head_slot[3:2] : head_slot[1:0];
        done      = sending && (cur_wq ? wq_ack : net_ack);
        pop       = done && (sel1 || !head_tv[1]);
        push      = in_valid && in_ready && (in_tgt_valid != 2'b00);
    end

    // Moore outputs decoded from state and FIFO head; payloads are zero when idle.
    always_comb begin
        net_req        = sending && !cur_wq;
        wq_req         = sending && cur_wq;
        net_data       = net_req ? head_data : '0;
        net_dest_instr = net_req ? cur_instr : 7'd0;
        net_dest_slot  = net_req ? cur_slot : 2'd0;
        wq_data        = wq_req ? head_data : '0;
        wq_id          = wq_req ? cur_instr[4:0] : 5'd0;
    end

    // Next-state, pointer and occupancy computation.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A head popped from a single-entry FIFO hands over straight to a same-cycle push.
        if (count_q > CW'(1)) begin
            after_pop = start_state(nxt_tv);
        end else if (push) begin
            after_pop = start_state(in_tgt_valid);
        end else begin
            after_pop = ST_IDLE;
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != CW'(0)) state_d = start_state(head_tv);
                else                   state_d = ST_IDLE;
            end
            ST_SEND0: begin
                if (done) state_d = head_tv[1] ? ST_SEND1 : after_pop;
                else      state_d = ST_SEND0;
            end
            ST_SEND1: begin
                if (done) state_d = after_pop;
                else      state_d = ST_SEND1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset outranks flush, which outranks normal operation.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through the head while sending.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q]  <= in_data;
            tv_mem_q[wr_ptr_q]    <= in_tgt_valid;
            wq_mem_q[wr_ptr_q]    <= in_tgt_wq;
            instr_mem_q[wr_ptr_q] <= in_tgt_instr;
            slot_mem_q[wr_ptr_q]  <= in_tgt_slot;
        end
    end

endmodule

// File: tb/tb_e_tile_operand_dispatch.sv
// Randomized bench for e_tile_operand_dispatch, checked every cycle against a
// queue-of-entries reference model of the dispatch rules.
module tb_e_tile_operand_dispatch;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_tgt_valid, in_tgt_wq;
    logic [13:0] in_tgt_instr;
    logic [3:0]  in_tgt_slot;
    logic        net_req, net_ack, wq_req, wq_ack;
    logic [63:0] net_data, wq_data;
    logic [6:0]  net_dest_instr, net_src_node;
    logic [1:0]  net_dest_slot;
    logic [4:0]  wq_id;
    logic [2:0]  occupancy;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  tv;
        logic [1:0]  wq;
        logic [13:0] instr;
        logic [3:0]  slot;
    } ent_t;

    ent_t mq[$];
    bit   m_busy;

    e_tile_operand_dispatch #(.DEPTH(4), .DATA_W(64), .NODE_ID(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tgt_valid(in_tgt_valid), .in_tgt_wq(in_tgt_wq),
        .in_tgt_instr(in_tgt_instr), .in_tgt_slot(in_tgt_slot),
        .net_req(net_req), .net_data(net_data), .net_dest_instr(net_dest_instr),
        .net_dest_slot(net_dest_slot), .net_src_node(net_src_node), .net_ack(net_ack),
        .wq_req(wq_req), .wq_id(wq_id), .wq_data(wq_data), .wq_ack(wq_ack),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // The target in service is the lowest still-pending target of the oldest entry.
    task automatic check_outputs();
        logic        e_nreq = 1'b0, e_wreq = 1'b0;
        logic [63:0] e_ndata = 64'd0, e_wdata = 64'd0;
        logic [6:0]  e_ninstr = 7'd0;
        logic [1:0]  e_nslot = 2'd0;
        logic [4:0]  e_wid = 5'd0;
        if (m_busy) begin
            int   t = mq[0].tv[0] ? 0 : 1;
            ent_t h = mq[0];
            if (h.wq[t]) begin
                e_wreq  = 1'b1;
                e_wdata = h.data;
                e_wid   = h.instr[t*7 +: 5];
            end else begin
                e_nreq   = 1'b1;
                e_ndata  = h.data;
                e_ninstr = h.instr[t*7 +: 7];
                e_nslot  = h.slot[t*2 +: 2];
            end
        end
        chk("in_ready", 64'(in_ready), 64'(!rst && !flush && (mq.size() < 4)));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("net_req", 64'(net_req), 64'(e_nreq));
        chk("net_data", net_data, e_ndata);
        chk("net_dest_instr", 64'(net_dest_instr), 64'(e_ninstr));
        chk("net_dest_slot", 64'(net_dest_slot), 64'(e_nslot));
        chk("net_src_node", 64'(net_src_node), 64'd0);
        chk("wq_req", 64'(wq_req), 64'(e_wreq));
        chk("wq_id", 64'(wq_id), 64'(e_wid));
        chk("wq_data", wq_data, e_wdata);
    endtask

    // Advance the reference model by one clock edge using the inputs just applied.
    task automatic model_step();
        if (rst || flush) begin
            mq.delete();
            m_busy = 1'b0;
        end else begin
            int n0     = mq.size();
            bit popped = 1'b0;
            if (m_busy) begin
                ent_t h = mq[0];
                int   t = h.tv[0] ? 0 : 1;
                if (h.wq[t] ? wq_ack : net_ack) begin
                    h.tv[t] = 1'b0;
                    mq[0] = h;
                    if (h.tv == 2'b00) begin
                        void'(mq.pop_front());
                        popped = 1'b1;
                    end
                end
            end
            if (in_valid && (n0 < 4) && (in_tgt_valid != 2'b00)) begin
                ent_t e;
                e.data  = in_data;
                e.tv    = in_tgt_valid;
                e.wq    = in_tgt_wq;
                e.instr = in_tgt_instr;
                e.slot  = in_tgt_slot;
                mq.push_back(e);
            end
            if (!m_busy)     m_busy = (n0 > 0);
            else if (popped) m_busy = (mq.size() > 0);
        end
    endtask

    initial begin
        int ack_pct;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0;
        in_tgt_valid = 2'b00; in_tgt_wq = 2'b00; in_tgt_instr = 14'd0; in_tgt_slot = 4'd0;
        net_ack = 1'b0; wq_ack = 1'b0;
        m_busy = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            case ((i / 250) % 3)
                0:       ack_pct = 90;
                1:       ack_pct = 5;
                default: ack_pct = 50;
            endcase
            rst          = (i == 0) || ($urandom_range(0, 299) == 0);
            flush        = !rst && ($urandom_range(0, 49) == 0);
            in_valid     = ($urandom_range(0, 99) < 70);
            in_data      = {$urandom, $urandom};
            in_tgt_valid = 2'($urandom_range(0, 3));
            in_tgt_wq    = 2'($urandom_range(0, 3));
            in_tgt_instr = 14'($urandom);
            in_tgt_slot  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            net_ack      = ($urandom_range(0, 99) < ack_pct);
            wq_ack       = ($urandom_range(0, 99) < ack_pct);
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
